// File: rtl/control_fsm.sv
// Top-level sequencing FSM of the processor control path: fetch, execute,
// load/store wait, halt and sticky trap. The registered state code is the output.
module control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic       halt,
  input  logic       instr_alu,
  input  logic       instr_pc,
  input  logic       ld,
  input  logic       st,
  input  logic       wait_data,
  input  logic       wait_instr,
  input  logic       data_segv,
  input  logic       instr_segv,
  input  logic       invalid_instruction,
  output logic [4:0] current_state
);

  typedef enum logic [4:0] {
    HALT       = 5'b00000,
    READ_INS   = 5'b01000,
    DO         = 5'b01001,
    WAIT_LOAD  = 5'b01010,
    WAIT_STORE = 5'b01100,
    TRAP       = 5'b10000
  } state_t;

  state_t r_state;

  // Instruction class bits stay on the port list for decoder compatibility only.
  logic w_unused;
  assign w_unused = ^{instr_alu, instr_pc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HALT;
    end else begin
      case (r_state)
        HALT: begin
          if (go && !halt) r_state <= READ_INS;
        end
        READ_INS: begin
          if (instr_segv)      r_state <= TRAP;
          else if (!wait_instr) r_state <= DO;
        end
        DO: begin
          if (invalid_instruction) r_state <= TRAP;
          else if (ld)             r_state <= WAIT_LOAD;
          else if (st)             r_state <= WAIT_STORE;
          else if (halt)           r_state <= HALT;
          else                     r_state <= READ_INS;
        end
        WAIT_LOAD, WAIT_STORE: begin
          if (data_segv)       r_state <= TRAP;
          else if (!wait_data) r_state <= halt ? HALT : READ_INS;
        end
        TRAP: r_state <= TRAP;
        default: r_state <= HALT;
      endcase
    end
  end

  assign current_state = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed scenarios with constant expectations, then
// randomized inputs checked against a rule-level reference model.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go, halt, instr_alu, instr_pc, ld, st;
  logic       wait_data, wait_instr, data_segv, instr_segv, invalid_instruction;
  logic [4:0] current_state;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam logic [4:0] C_HALT = 5'b00000;
  localparam logic [4:0] C_READ = 5'b01000;
  localparam logic [4:0] C_DO   = 5'b01001;
  localparam logic [4:0] C_WLD  = 5'b01010;
  localparam logic [4:0] C_WST  = 5'b01100;
  localparam logic [4:0] C_TRAP = 5'b10000;

  control_fsm dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .go                  (go),
    .halt                (halt),
    .instr_alu           (instr_alu),
    .instr_pc            (instr_pc),
    .ld                  (ld),
    .st                  (st),
    .wait_data           (wait_data),
    .wait_instr          (wait_instr),
    .data_segv           (data_segv),
    .instr_segv          (instr_segv),
    .invalid_instruction (invalid_instruction),
    .current_state       (current_state)
  );

  always #5 clk = ~clk;

  // Next state from the written sequencing rules, priorities top to bottom.
  function automatic logic [4:0] ref_next(input logic [4:0] s);
    if (s == C_HALT)      return (go && !halt) ? C_READ : C_HALT;
    if (s == C_READ)      return instr_segv ? C_TRAP : (wait_instr ? C_READ : C_DO);
    if (s == C_DO) begin
      if (invalid_instruction) return C_TRAP;
      if (ld)                  return C_WLD;
      if (st)                  return C_WST;
      return halt ? C_HALT : C_READ;
    end
    if (s == C_WLD || s == C_WST) begin
      if (data_segv) return C_TRAP;
      if (wait_data) return s;
      return halt ? C_HALT : C_READ;
    end
    if (s == C_TRAP)      return C_TRAP;
    return C_HALT;
  endfunction

  task automatic clear_inputs();
    go = 0; halt = 0; instr_alu = 0; instr_pc = 0; ld = 0; st = 0;
    wait_data = 0; wait_instr = 0; data_segv = 0; instr_segv = 0;
    invalid_instruction = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(posedge clk);
    #3 reset_n = 0;
    #4 reset_n = 1;
    #1;
  endtask

  // Reset, then one go pulse: HALT -> READ_INS -> DO -> READ_INS ...
  task automatic enter_do();
    go = 1;
    tick();
    go = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    #12;
    vectors++;
    if (current_state !== C_HALT) begin
      miscompares++; $display("FAIL reset_low: got %b want %b", current_state, C_HALT);
    end
    reset_n = 1;
    tick();
    vectors++;
    if (current_state !== C_HALT) begin
      miscompares++; $display("FAIL reset_idle: got %b want %b", current_state, C_HALT);
    end
  endtask

  task automatic test_fetch_loop();
    apply_reset();
    go = 1;
    tick();
    go = 0;
    vectors++;
    if (current_state !== C_READ) begin
      miscompares++; $display("FAIL go_to_read: got %b want %b", current_state, C_READ);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (current_state !== ((i % 2 == 0) ? C_DO : C_READ)) begin
        miscompares++;
        $display("FAIL fetch_toggle[%0d]: got %b want %b", i, current_state,
                 (i % 2 == 0) ? C_DO : C_READ);
      end
    end
  endtask

  task automatic test_load_stall();
    apply_reset();
    enter_do();
    ld = 1; wait_data = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ld = 0;
      vectors++;
      if (current_state !== C_WLD) begin
        miscompares++; $display("FAIL load_hold[%0d]: got %b want %b", i, current_state, C_WLD);
      end
    end
    wait_data = 0;
    tick();
    vectors++;
    if (current_state !== C_READ) begin
      miscompares++; $display("FAIL load_done: got %b want %b", current_state, C_READ);
    end
  endtask

  task automatic test_store();
    apply_reset();
    enter_do();
    st = 1;
    tick();
    st = 0;
    vectors++;
    if (current_state !== C_WST) begin
      miscompares++; $display("FAIL store_enter: got %b want %b", current_state, C_WST);
    end
    tick();
    vectors++;
    if (current_state !== C_READ) begin
      miscompares++; $display("FAIL store_done: got %b want %b", current_state, C_READ);
    end
    tick();
    ld = 1; st = 1;
    tick();
    ld = 0; st = 0;
    vectors++;
    if (current_state !== C_WLD) begin
      miscompares++; $display("FAIL ld_over_st: got %b want %b", current_state, C_WLD);
    end
  endtask

  task automatic test_faults();
    apply_reset();
    go = 1;
    tick();
    go = 0; instr_segv = 1;
    tick();
    instr_segv = 0;
    vectors++;
    if (current_state !== C_TRAP) begin
      miscompares++; $display("FAIL instr_segv: got %b want %b", current_state, C_TRAP);
    end

    apply_reset();
    enter_do();
    st = 1;
    tick();
    st = 0; data_segv = 1; wait_data = 1;
    tick();
    data_segv = 0; wait_data = 0;
    vectors++;
    if (current_state !== C_TRAP) begin
      miscompares++; $display("FAIL data_segv: got %b want %b", current_state, C_TRAP);
    end

    apply_reset();
    // data_segv outside wait states must be ignored
    data_segv = 1;
    enter_do();
    data_segv = 0;
    invalid_instruction = 1; ld = 1;
    vectors++;
    if (current_state !== C_DO) begin
      miscompares++; $display("FAIL segv_ignored: got %b want %b", current_state, C_DO);
    end
    tick();
    invalid_instruction = 0; ld = 0;
    vectors++;
    if (current_state !== C_TRAP) begin
      miscompares++; $display("FAIL invalid_instr: got %b want %b", current_state, C_TRAP);
    end
    go = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (current_state !== C_TRAP) begin
        miscompares++; $display("FAIL trap_sticky[%0d]: got %b want %b", i, current_state, C_TRAP);
      end
    end
    #2 reset_n = 0;
    #1;
    vectors++;
    if (current_state !== C_HALT) begin
      miscompares++; $display("FAIL async_reset: got %b want %b", current_state, C_HALT);
    end
    tick();
    vectors++;
    if (current_state !== C_HALT) begin
      miscompares++; $display("FAIL reset_hold_go: got %b want %b", current_state, C_HALT);
    end
    #2 reset_n = 1;
    go = 0;
  endtask

  task automatic test_halt();
    apply_reset();
    enter_do();
    halt = 1;
    tick();
    halt = 0;
    vectors++;
    if (current_state !== C_HALT) begin
      miscompares++; $display("FAIL halt_in_do: got %b want %b", current_state, C_HALT);
    end

    enter_do();
    ld = 1; wait_data = 1;
    tick();
    ld = 0; halt = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (current_state !== C_WLD) begin
        miscompares++; $display("FAIL halt_wait[%0d]: got %b want %b", i, current_state, C_WLD);
      end
    end
    wait_data = 0;
    tick();
    vectors++;
    if (current_state !== C_HALT) begin
      miscompares++; $display("FAIL halt_after_load: got %b want %b", current_state, C_HALT);
    end

    go = 1; halt = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (current_state !== C_HALT) begin
        miscompares++; $display("FAIL halt_over_go[%0d]: got %b want %b", i, current_state, C_HALT);
      end
    end
    go = 0; halt = 0;
  endtask

  task automatic test_fetch_stall();
    apply_reset();
    go = 1;
    tick();
    go = 0; wait_instr = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (current_state !== C_READ) begin
        miscompares++; $display("FAIL fetch_stall[%0d]: got %b want %b", i, current_state, C_READ);
      end
    end
    wait_instr = 0;
    tick();
    vectors++;
    if (current_state !== C_DO) begin
      miscompares++; $display("FAIL fetch_release: got %b want %b", current_state, C_DO);
    end
  endtask

  task automatic test_random();
    logic [4:0] m_state;
    logic [4:0] m_next;
    apply_reset();
    m_state = C_HALT;
    for (int n = 0; n < 3000; n++) begin
      go                  = ($urandom_range(0, 3) != 0);
      halt                = ($urandom_range(0, 7) == 0);
      instr_alu           = $urandom_range(0, 1) == 1;
      instr_pc            = $urandom_range(0, 1) == 1;
      ld                  = ($urandom_range(0, 3) == 0);
      st                  = ($urandom_range(0, 3) == 0);
      wait_data           = ($urandom_range(0, 2) == 0);
      wait_instr          = ($urandom_range(0, 2) == 0);
      data_segv           = ($urandom_range(0, 31) == 0);
      instr_segv          = ($urandom_range(0, 31) == 0);
      invalid_instruction = ($urandom_range(0, 31) == 0);
      if (m_state == C_TRAP && $urandom_range(0, 3) == 0) begin
        #2 reset_n = 0;
        #1;
        vectors++;
        if (current_state !== C_HALT) begin
          miscompares++; $display("FAIL rand_reset[%0d]: got %b want %b", n, current_state, C_HALT);
        end
        #1 reset_n = 1;
        m_state = C_HALT;
      end
      m_next = ref_next(m_state);
      tick();
      vectors++;
      if (current_state !== m_next) begin
        miscompares++;
        $display("FAIL rand_step[%0d]: got %b want %b (from %b)", n, current_state, m_next, m_state);
      end
      m_state = m_next;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch_loop();
    test_load_stall();
    test_store();
    test_faults();
    test_halt();
    test_fetch_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
